// File: rtl/vga_pkg.sv
// Shared VGA playfield geometry, ball-state encoding and a row-overlap helper
// for the pong overlay stages.
package vga_pkg;

    localparam int PLAY_TOP     = 51;
    localparam int PLAY_BOTTOM  = 717;
    localparam int SCREEN_RIGHT = 1023;

    localparam logic [10:0] CENTRE_X = 11'd506;
    localparam logic [10:0] CENTRE_Y = 11'd378;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE,
        ST_SCORED
    } ball_state_t;

    // True when rows [ball_top, ball_top+ball_h) and [pad_top, pad_top+pad_h) intersect.
    function automatic logic rows_overlap(
        input logic [10:0] ball_top,
        input logic [10:0] pad_top,
        input int          ball_h,
        input int          pad_h
    );
        logic [12:0] b;
        logic [12:0] p;
        b = {2'b00, ball_top};
        p = {2'b00, pad_top};
        return (b < p + 13'(pad_h)) && (p < b + 13'(ball_h));
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle (counters, syncs, blanking, colour) passed between
// pipeline stages.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/ball_ctl.sv
// Ball game-state controller: serve delay, per-frame motion, wall and paddle
// bounces, and one-cycle score pulses.
module ball_ctl
    import vga_pkg::*;
#(
    parameter int BALL_SIZE    = 12,
    parameter int SPEED        = 4,
    parameter int PADDLE_L_X   = 40,
    parameter int PADDLE_R_X   = 974,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 96,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        game_active,
    input  logic        vblnk,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        ball_on,
    output logic        score_l,
    output logic        score_r
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [11:0] SPD    = 12'(SPEED);
    localparam logic signed [11:0] BSZ    = 12'(BALL_SIZE);
    localparam logic signed [11:0] L_FACE = 12'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [11:0] R_FACE = 12'(PADDLE_R_X);
    localparam logic signed [11:0] TOP    = 12'(PLAY_TOP);
    localparam logic signed [11:0] BOT    = 12'(PLAY_BOTTOM);
    localparam logic signed [11:0] RIGHT  = 12'(SCREEN_RIGHT);

    ball_state_t      state_q, state_d;
    logic [10:0]      ball_x_q, ball_x_d;
    logic [10:0]      ball_y_q, ball_y_d;
    logic             dir_x_q, dir_x_d;     // 1 = right
    logic             dir_y_q, dir_y_d;     // 1 = down
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vblnk_prev_q, vblnk_prev_d;
    logic             score_l_q, score_l_d;
    logic             score_r_q, score_r_d;

    logic               tick;
    logic signed [11:0] x_s, y_s, nx, ny;
    logic               ovl_l, ovl_r, hit_l, hit_r, out_l, out_r;

    always_comb begin
        tick = vblnk & ~vblnk_prev_q;
        x_s  = signed'({1'b0, ball_x_q});
        y_s  = signed'({1'b0, ball_y_q});
        nx   = dir_x_q ? x_s + SPD : x_s - SPD;
        ny   = dir_y_q ? y_s + SPD : y_s - SPD;

        ovl_l = rows_overlap(ball_y_q, paddle_l_y, BALL_SIZE, PADDLE_H);
        ovl_r = rows_overlap(ball_y_q, paddle_r_y, BALL_SIZE, PADDLE_H);
        // A hit needs the ball to cross the paddle face this tick, not already be past it.
        hit_l = !dir_x_q && (nx < L_FACE) && (x_s >= L_FACE) && ovl_l;
        hit_r = dir_x_q && (nx + BSZ - 12'sd1 >= R_FACE) && (x_s + BSZ - 12'sd1 < R_FACE) && ovl_r;
        out_l = !dir_x_q && (x_s < SPD);
        out_r = dir_x_q && (x_s + BSZ - 12'sd1 + SPD > RIGHT);

        state_d      = state_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        cnt_d        = cnt_q;
        vblnk_prev_d = vblnk;
        score_l_d    = 1'b0;
        score_r_d    = 1'b0;

        if (!game_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SERVE;
                    ball_x_d = CENTRE_X;
                    ball_y_d = CENTRE_Y;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b1;
                    cnt_d    = '0;
                end
                ST_SERVE: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                            state_d = ST_MOVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_MOVE: begin
                    if (tick) begin
                        if (!hit_l && !hit_r && (out_l || out_r)) begin
                            // The serve heads toward whoever let the ball through.
                            state_d   = ST_SCORED;
                            score_r_d = out_l;
                            score_l_d = out_r;
                            dir_x_d   = out_r;
                        end else begin
                            if (hit_l) begin
                                ball_x_d = L_FACE[10:0];
                                dir_x_d  = 1'b1;
                            end else if (hit_r) begin
                                ball_x_d = 11'(PADDLE_R_X - BALL_SIZE);
                                dir_x_d  = 1'b0;
                            end else begin
                                ball_x_d = nx[10:0];
                            end
                            if (ny < TOP) begin
                                ball_y_d = TOP[10:0];
                                dir_y_d  = 1'b1;
                            end else if (ny + BSZ - 12'sd1 > BOT) begin
                                ball_y_d = 11'(PLAY_BOTTOM + 1 - BALL_SIZE);
                                dir_y_d  = 1'b0;
                            end else begin
                                ball_y_d = ny[10:0];
                            end
                        end
                    end
                end
                ST_SCORED: begin
                    state_d  = ST_SERVE;
                    ball_x_d = CENTRE_X;
                    ball_y_d = CENTRE_Y;
                    cnt_d    = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ball_x_q     <= CENTRE_X;
            ball_y_q     <= CENTRE_Y;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            cnt_q        <= '0;
            vblnk_prev_q <= 1'b0;
            score_l_q    <= 1'b0;
            score_r_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            cnt_q        <= cnt_d;
            vblnk_prev_q <= vblnk_prev_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
        end
    end

    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign ball_on = (state_q != ST_IDLE);
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: rtl/draw_ball.sv
// Ball overlay stage: delays the VGA stream one cycle and paints the ball
// square on top of the background colour.
module draw_ball
    import vga_pkg::*;
#(
    parameter int          BALL_SIZE    = 12,
    parameter int          SPEED        = 4,
    parameter int          PADDLE_L_X   = 40,
    parameter int          PADDLE_R_X   = 974,
    parameter int          PADDLE_W     = 10,
    parameter int          PADDLE_H     = 96,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [11:0] BALL_COLOR   = 12'hf_f_f
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        game_active,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    vga_if.in           in_if,
    vga_if.out          out_if,
    output logic        score_l,
    output logic        score_r
);

    logic [10:0] ball_x, ball_y;
    logic        ball_on;

    ball_ctl #(
        .BALL_SIZE   (BALL_SIZE),
        .SPEED       (SPEED),
        .PADDLE_L_X  (PADDLE_L_X),
        .PADDLE_R_X  (PADDLE_R_X),
        .PADDLE_W    (PADDLE_W),
        .PADDLE_H    (PADDLE_H),
        .SERVE_FRAMES(SERVE_FRAMES)
    ) u_ball_ctl (
        .clk65MHz   (clk65MHz),
        .rst        (rst),
        .game_active(game_active),
        .vblnk      (in_if.vblnk),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_on    (ball_on),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    logic [10:0] vcount_q, vcount_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic [10:0] hcount_q, hcount_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic [11:0] rgb_q, rgb_d;
    logic        in_box;

    always_comb begin
        // Extend to 12 bits so the box end cannot wrap near the screen edge.
        in_box = ball_on && !in_if.hblnk && !in_if.vblnk
              && ({1'b0, in_if.hcount} >= {1'b0, ball_x})
              && ({1'b0, in_if.hcount} <  {1'b0, ball_x} + 12'(BALL_SIZE))
              && ({1'b0, in_if.vcount} >= {1'b0, ball_y})
              && ({1'b0, in_if.vcount} <  {1'b0, ball_y} + 12'(BALL_SIZE));
        vcount_d = in_if.vcount;
        vsync_d  = in_if.vsync;
        vblnk_d  = in_if.vblnk;
        hcount_d = in_if.hcount;
        hsync_d  = in_if.hsync;
        hblnk_d  = in_if.hblnk;
        rgb_d    = in_box ? BALL_COLOR : in_if.rgb;
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            vcount_q <= '0;
            vsync_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hcount_q <= '0;
            hsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            vcount_q <= vcount_d;
            vsync_q  <= vsync_d;
            vblnk_q  <= vblnk_d;
            hcount_q <= hcount_d;
            hsync_q  <= hsync_d;
            hblnk_q  <= hblnk_d;
            rgb_q    <= rgb_d;
        end
    end

    assign out_if.vcount = vcount_q;
    assign out_if.vsync  = vsync_q;
    assign out_if.vblnk  = vblnk_q;
    assign out_if.hcount = hcount_q;
    assign out_if.hsync  = hsync_q;
    assign out_if.hblnk  = hblnk_q;
    assign out_if.rgb    = rgb_q;

endmodule

// File: doc/draw_ball.md
DRAW_BALL -- requirements
Module: draw_ball

Interface
REQ-001 Parameter BALL_SIZE, 12, ball square edge in pixels.
REQ-002 Parameter SPEED, 4, pixels moved per frame on each axis.
REQ-003 Parameter PADDLE_L_X, 40, leftmost column of left paddle.
REQ-004 Parameter PADDLE_R_X, 974, leftmost column of right paddle.
REQ-005 Parameter PADDLE_W, 10, paddle width; PADDLE_H, 96, paddle height.
REQ-006 Parameter SERVE_FRAMES, 60, frames ball rests at centre before moving.
REQ-007 Parameter BALL_COLOR, 12'hf_f_f, ball RGB.
REQ-008 clk65MHz  in  1  pixel clock; all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 game_active  in  1  high during single- or multi-player game screen.
REQ-011 paddle_l_y, paddle_r_y  in  11 each  top row of each paddle.
REQ-012 in_if  vga_if.in  -  timing + rgb from background stage.
REQ-013 out_if  vga_if.out  -  timing + rgb with ball overlaid.
REQ-014 score_l, score_r  out  1 each  one-cycle pulse: left/right player scored.

Function
REQ-015 Playfield rows 51..717 inclusive; screen columns 0..1023.
REQ-016 Frame tick = rising edge of in_if.vblnk (registered previous value); ball state updates only on tick.
REQ-017 FSM states IDLE, SERVE, MOVE, SCORED.
REQ-018 IDLE: ball hidden; game_active=1 -> SERVE with ball_x=506, ball_y=378, dir_x=right, dir_y=down, frame counter=0.
REQ-019 SERVE: ball drawn at centre; counter increments per tick; at SERVE_FRAMES ticks -> MOVE.
REQ-020 MOVE: per tick, x +/- SPEED, y +/- SPEED per dir_x/dir_y.
REQ-021 Next y < 51 -> y=51, dir_y=down; next y+BALL_SIZE-1 > 717 -> y=718-BALL_SIZE, dir_y=up.
REQ-022 Moving left, next x <= PADDLE_L_X+PADDLE_W-1, current x >= PADDLE_L_X+PADDLE_W, rows overlap [paddle_l_y, paddle_l_y+PADDLE_H) -> x=PADDLE_L_X+PADDLE_W, dir_x=right.
REQ-023 Moving right, next x+BALL_SIZE-1 >= PADDLE_R_X, current x+BALL_SIZE-1 < PADDLE_R_X, rows overlap right paddle -> x=PADDLE_R_X-BALL_SIZE, dir_x=left.
REQ-024 Paddle check precedes edge check; y-bounce and paddle bounce in same tick both applied.
REQ-025 Moving left, x < SPEED with no paddle hit -> score_r pulse, SCORED; moving right, x+BALL_SIZE-1+SPEED > 1023 with no hit -> score_l pulse, SCORED.
REQ-026 SCORED lasts one cycle -> SERVE, ball at centre, dir_x toward the player who conceded.
REQ-027 Score pulses exactly one clk65MHz cycle; never both in one cycle.
REQ-028 game_active=0 in any state -> IDLE on next cycle; no pulse generated.
REQ-029 Position arithmetic 12-bit signed internally; stored x,y 11-bit unsigned.
REQ-030 Overlay latency 1 cycle: all out_if timing fields = in_if fields delayed one cycle.
REQ-031 out_if.rgb = BALL_COLOR when state != IDLE, in_if hblnk=vblnk=0, hcount in [x,x+BALL_SIZE), vcount in [y,y+BALL_SIZE); else in_if.rgb.

Reset
REQ-032 On rst: out_if all fields 0, score pulses 0, state IDLE, ball_x=506, ball_y=378, dir_x=right, dir_y=down, counter 0, vblnk history 0.
REQ-033 rst mid-MOVE overrides all; first post-reset tick causes no motion.

Structure
REQ-034 Playfield bounds (51, 717), centre coordinates and state enum in vga_pkg.
REQ-035 Sub-module ball_ctl holds FSM, counter and position; draw_ball holds overlay pipeline.

Verification
REQ-036 game_active=1 from reset -> ball at (506,378) for 60 ticks, then (510,382) on tick 61.
REQ-037 Ball y=53 moving up, SPEED 4 -> next tick y=51, dir_y=down; following tick y=55.
REQ-038 Ball x=52 moving left, paddle_l_y=300, ball_y=350 -> x=50, dir_x=right, no score pulse.
REQ-039 Ball x=2 moving left, paddle_l_y=0, ball_y=600 -> score_r high one cycle, ball to (506,378), dir_x=left.
REQ-040 Pixel (hcount=506, vcount=378) during SERVE -> out rgb 12'hfff one cycle later; pixel (505,378) -> in rgb passed.
REQ-041 game_active dropped during MOVE -> IDLE next cycle, ball not drawn, no score pulse.
